// File: rtl/uart_rx.sv
// Oversampled UART receiver: majority-voted bit sampling, LSB-first deserialization,
// optional even/odd parity and stop-bit checking with one-cycle result strobes.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);
    // state  | meaning
    // IDLE   | line idle, waiting for a low level (start detection = edge 0)
    // START  | checking start bit, glitch aborts back to IDLE
    // DATA   | shifting in DATA_WIDTH payload bits LSB-first
    // PARITY | comparing received parity bit against payload
    // STOP   | checking stop bit, strobes raised on exit
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [5:0]            edge_cnt;
    logic [5:0]            p_lat;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  s0;
    logic                  s1;
    logic                  bit_val;
    logic                  par_bad;

    logic [5:0] half;
    logic       edge_last;
    logic       prescale_ok;
    logic       frame_bad_par;

    assign half          = {1'b0, p_lat[5:1]};
    assign edge_last     = (edge_cnt == (p_lat - 6'd1));
    assign prescale_ok   = (PRESCALE == 6'd8) || (PRESCALE == 6'd16) || (PRESCALE == 6'd32);
    assign frame_bad_par = par_en_l & par_bad;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            edge_cnt   <= 6'd0;
            p_lat      <= 6'd8;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            bit_val    <= 1'b1;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state == S_IDLE) begin
                // The detecting cycle already counts as edge 0 of the start bit.
                if (!RX_IN) begin
                    state     <= S_START;
                    edge_cnt  <= 6'd1;
                    p_lat     <= prescale_ok ? PRESCALE : 6'd8;
                    par_en_l  <= PAR_EN;
                    par_typ_l <= PAR_TYP;
                    bit_cnt   <= '0;
                    par_bad   <= 1'b0;
                end
            end else begin
                edge_cnt <= edge_last ? 6'd0 : edge_cnt + 6'd1;
                if (edge_cnt == half - 6'd1) s0 <= RX_IN;
                if (edge_cnt == half)        s1 <= RX_IN;
                if (edge_cnt == half + 6'd1) bit_val <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
                if (edge_last) begin
                    case (state)
                        S_START: state <= bit_val ? S_IDLE : S_DATA;
                        S_DATA: begin
                            shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= par_en_l ? S_PARITY : S_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        S_PARITY: begin
                            par_bad <= (bit_val != ((^shift_reg) ^ par_typ_l));
                            state   <= S_STOP;
                        end
                        S_STOP: begin
                            stp_err    <= ~bit_val;
                            par_err    <= frame_bad_par;
                            data_valid <= bit_val & ~frame_bad_par;
                            if (bit_val && !frame_bad_par) P_DATA <= shift_reg;
                            state      <= S_IDLE;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: frame timing, parity/stop errors,
// false start, back-to-back frames, mid-frame reset, sample glitch, illegal prescale.
module tb_uart_rx;
    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    int         dv_cyc = 0, dv_cyc_prev = 0, pe_cyc = 0, se_cyc = 0;
    logic [7:0] dv_data = 8'h00, dv_data_prev = 8'h00;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_n <= edge_n + 1;

    // Records strobe occurrences with the cycle index they were seen in.
    always @(negedge CLK) begin
        if (data_valid) begin
            dv_cnt       <= dv_cnt + 1;
            dv_cyc       <= edge_n;
            dv_cyc_prev  <= dv_cyc;
            dv_data      <= P_DATA;
            dv_data_prev <= dv_data;
        end
        if (par_err) begin
            pe_cnt <= pe_cnt + 1;
            pe_cyc <= edge_n;
        end
        if (stp_err) begin
            se_cnt <= se_cnt + 1;
            se_cyc <= edge_n;
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Drives a full frame starting at the current negedge; glitch inverts one cycle.
    task automatic send_frame(input logic [7:0] data, input int p, input bit has_par,
                              input bit par_bit, input bit stop_bit,
                              input int glitch_idx, input int glitch_edge, output int start);
        logic [11:0] bits;
        int n;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        n = 9;
        if (has_par) begin
            bits[n] = par_bit;
            n++;
        end
        bits[n] = stop_bit;
        n++;
        start = edge_n;
        for (int i = 0; i < n; i++) begin
            for (int e = 0; e < p; e++) begin
                RX_IN = (i == glitch_idx && e == glitch_edge) ? ~bits[i] : bits[i];
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_p_data got=%h exp=00", P_DATA); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        checks++; if ({par_err, stp_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got=%b exp=00", {par_err, stp_err}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        RST = 1'b1;
        idle(4);
    endtask

    task automatic test_parity_even();
        int start, dv0, pe0, se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, -1, start);
        idle(4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL even_dv_count got=%0d exp=1", dv_cnt - dv0); end
        checks++; if (dv_cyc - start !== 88) begin errors++; $display("FAIL even_dv_latency got=%0d exp=88", dv_cyc - start); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL even_p_data got=%h exp=a5", P_DATA); end
        checks++; if (dv_data !== 8'hA5) begin errors++; $display("FAIL even_dv_data got=%h exp=a5", dv_data); end
        checks++; if ((pe_cnt - pe0) + (se_cnt - se0) !== 0) begin errors++; $display("FAIL even_no_errs got=%0d exp=0", (pe_cnt - pe0) + (se_cnt - se0)); end
    endtask

    task automatic test_parity_err();
        int start, dv0, pe0;
        dv0 = dv_cnt; pe0 = pe_cnt;
        PRESCALE = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1, -1, start);
        idle(4);
        checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL odd_pe_count got=%0d exp=1", pe_cnt - pe0); end
        checks++; if (pe_cyc - start !== 176) begin errors++; $display("FAIL odd_pe_latency got=%0d exp=176", pe_cyc - start); end
        checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL odd_no_dv got=%0d exp=0", dv_cnt - dv0); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL odd_p_data_hold got=%h exp=a5", P_DATA); end
    endtask

    task automatic test_stop_err();
        int start, dv0, se0;
        dv0 = dv_cnt; se0 = se_cnt;
        PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, -1, -1, start);
        idle(4);
        checks++; if (se_cnt - se0 !== 1) begin errors++; $display("FAIL stop_se_count got=%0d exp=1", se_cnt - se0); end
        checks++; if (se_cyc - start !== 80) begin errors++; $display("FAIL stop_se_latency got=%0d exp=80", se_cyc - start); end
        checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL stop_no_dv got=%0d exp=0", dv_cnt - dv0); end
        idle(12);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1, -1, start);
        idle(4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL stop_next_dv got=%0d exp=1", dv_cnt - dv0); end
        checks++; if (P_DATA !== 8'h55) begin errors++; $display("FAIL stop_next_data got=%h exp=55", P_DATA); end
    endtask

    task automatic test_false_start();
        int dv0, pe0, se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        PRESCALE = 6'd8; PAR_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_busy_c3 got=%b exp=1", busy); end
        repeat (4) @(negedge CLK);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_busy_c7 got=%b exp=1", busy); end
        @(negedge CLK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_busy_c8 got=%b exp=0", busy); end
        idle(100);
        checks++; if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin errors++; $display("FAIL false_no_flags got=%0d exp=0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)); end
    endtask

    task automatic test_back_to_back();
        int s1, s2, dv0;
        dv0 = dv_cnt;
        PRESCALE = 6'd32; PAR_EN = 1'b0;
        send_frame(8'h12, 32, 1'b0, 1'b0, 1'b1, -1, -1, s1);
        send_frame(8'h34, 32, 1'b0, 1'b0, 1'b1, -1, -1, s2);
        idle(4);
        checks++; if (dv_cnt - dv0 !== 2) begin errors++; $display("FAIL b2b_dv_count got=%0d exp=2", dv_cnt - dv0); end
        checks++; if (dv_cyc - dv_cyc_prev !== 320) begin errors++; $display("FAIL b2b_spacing got=%0d exp=320", dv_cyc - dv_cyc_prev); end
        checks++; if (dv_cyc - s1 !== 640) begin errors++; $display("FAIL b2b_latency got=%0d exp=640", dv_cyc - s1); end
        checks++; if (dv_data_prev !== 8'h12) begin errors++; $display("FAIL b2b_first got=%h exp=12", dv_data_prev); end
        checks++; if (dv_data !== 8'h34) begin errors++; $display("FAIL b2b_second got=%h exp=34", dv_data); end
    endtask

    task automatic test_reset_mid();
        int start, dv0, pe0, se0;
        PRESCALE = 6'd8; PAR_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (36) @(negedge CLK);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if ({busy, data_valid, par_err, stp_err} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags got=%b exp=0000", {busy, data_valid, par_err, stp_err}); end
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL rstmid_p_data got=%h exp=00", P_DATA); end
        @(negedge CLK);
        RST = 1'b1;
        idle(3);
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'hF0, 8, 1'b0, 1'b0, 1'b1, -1, -1, start);
        idle(4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL rstmid_next_dv got=%0d exp=1", dv_cnt - dv0); end
        checks++; if (P_DATA !== 8'hF0) begin errors++; $display("FAIL rstmid_next_data got=%h exp=f0", P_DATA); end
        checks++; if ((pe_cnt - pe0) + (se_cnt - se0) !== 0) begin errors++; $display("FAIL rstmid_next_errs got=%0d exp=0", (pe_cnt - pe0) + (se_cnt - se0)); end
    endtask

    task automatic test_glitch();
        int start, dv0, pe0;
        dv0 = dv_cnt; pe0 = pe_cnt;
        PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        // data bit 2 is frame bit index 3; P/2 = 4
        send_frame(8'h0F, 8, 1'b1, 1'b0, 1'b1, 3, 4, start);
        idle(4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL glitch_dv got=%0d exp=1", dv_cnt - dv0); end
        checks++; if (P_DATA !== 8'h0F) begin errors++; $display("FAIL glitch_data got=%h exp=0f", P_DATA); end
        checks++; if (pe_cnt - pe0 !== 0) begin errors++; $display("FAIL glitch_no_pe got=%0d exp=0", pe_cnt - pe0); end
    endtask

    task automatic test_illegal_prescale();
        int start, dv0;
        dv0 = dv_cnt;
        PRESCALE = 6'd12; PAR_EN = 1'b0;
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, -1, -1, start);
        idle(4);
        checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL illegal_dv got=%0d exp=1", dv_cnt - dv0); end
        checks++; if (dv_cyc - start !== 80) begin errors++; $display("FAIL illegal_latency got=%0d exp=80", dv_cyc - start); end
        checks++; if (P_DATA !== 8'hC3) begin errors++; $display("FAIL illegal_data got=%h exp=c3", P_DATA); end
    endtask

    initial begin
        RST = 1'b0; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        @(negedge CLK);
        test_reset();
        test_parity_even();
        test_parity_err();
        test_stop_err();
        test_false_start();
        test_back_to_back();
        test_reset_mid();
        test_glitch();
        test_illegal_prescale();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. It is the receive-side counterpart of the team's UART TX path (serializer, parity calculator, FSM). It runs on an oversampling clock, detects start bits, and majority-samples each bit. It deserializes DATA_WIDTH bits LSB-first, checks optional even/odd parity and the stop bit, then presents the byte with a one-cycle valid strobe or error strobes.

Parameters:
DATA_WIDTH, 8, payload bits per frame

Ports:
CLK  input  1  oversampling clock (PRESCALE ticks per bit)
RST  input  1  asynchronous, active-low reset
RX_IN  input  1  serial line, idle high (already synchronized upstream)
PRESCALE  input  6  oversampling ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = parity bit present in frame
PAR_TYP  input  1  0 = even (parity bit = XOR of data), 1 = odd (inverted XOR)
P_DATA  output  DATA_WIDTH  last correctly received payload
data_valid  output  1  one-cycle pulse: good frame, P_DATA updated
par_err  output  1  one-cycle pulse: parity mismatch
stp_err  output  1  one-cycle pulse: stop bit sampled 0
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (RST=0, async): state IDLE; all counters 0; P_DATA=0; data_valid=par_err=stp_err=busy=0.
- Config latching: PRESCALE, PAR_EN and PAR_TYP are captured on start detection and held for the frame. Changes mid-frame have no effect. An illegal PRESCALE is latched as 8.
- Counters: edge_cnt counts 0..P-1 within a bit, where P is the latched PRESCALE. bit_cnt counts bits within the current state.
- Sampling: RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three samples, resolved by edge_cnt = P-1.
- All state transitions occur on the cycle where edge_cnt = P-1.
- State machine:
  - IDLE: busy=0. The first cycle with RX_IN=0 moves to START; that cycle is edge_cnt=0 of the start bit.
  - START (busy=1): if the resolved value is 1 (glitch), return to IDLE with no flags. Otherwise go to DATA.
  - DATA: DATA_WIDTH bits, shifted LSB-first into an internal shift register. After the last bit, go to PARITY if PAR_EN=1, else STOP.
  - PARITY: compute expected = (^shift) ^ PAR_TYP and record a mismatch. Go to STOP.
  - STOP: at the end of the stop bit, return to IDLE and raise the flags.
- Flags are registered. They are high for exactly one CLK, the cycle after the stop bit's edge_cnt = P-1:
  - stp_err = resolved stop bit is 0.
  - par_err = PAR_EN and parity mismatch.
  - data_valid = neither error.
- P_DATA loads the shift register only when data_valid fires; it holds otherwise, including on error frames.
- Frame length: (2 + DATA_WIDTH + PAR_EN) * P cycles from start detection to the flag cycle.
- Back-to-back frames: the flag cycle is spent in IDLE. If RX_IN=0 in that cycle, it is edge 0 of the next start bit, so zero idle gap is supported and no frame is lost.
- Stop-error frame: after a stop error, RX_IN still low (break) is treated as a new start bit.
- Reset mid-frame: the frame is discarded immediately, with no flags.
- Single-sample noise: a one-cycle glitch on any one of the three sample points does not change the resolved bit.

Test Plan:
- P=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 (LSB-first 1,0,1,0,0,1,0,1; parity 0; stop 1) -> data_valid=1 for one cycle, 88 cycles after start detection; P_DATA=0xA5; par_err=stp_err=0.
- P=16, PAR_EN=1, PAR_TYP=1, 0x3C sent with parity bit 0 (correct odd bit is 1) -> par_err pulse at cycle 176; data_valid=0; P_DATA keeps its previous value.
- P=8, PAR_EN=0, 0x81 with stop bit 0 -> stp_err pulse at cycle 80; data_valid=0. The line then returns high and a following frame 0x55 is received with data_valid=1.
- RX_IN low for 3 cycles at P=8, then high -> START aborts to IDLE; no flags; busy falls after 8 cycles.
- P=32, two back-to-back frames 0x12, 0x34 with zero gap and PAR_EN=0 -> two data_valid pulses 320 cycles apart, carrying P_DATA 0x12 then 0x34.
- RST asserted during DATA bit 4, then released -> all outputs 0; the next full frame 0xF0 is received correctly. Also: one-cycle inverted glitch at sample point P/2 of data bit 2 -> byte unaffected.
